// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer driving one external combinational full-adder cell.
// Operands are latched on a start handshake, processed LSB first, and the result is held until consumed.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             startValid,
  output logic             startReady,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             opSub,
  output logic             faX,
  output logic             faY,
  output logic             faCin,
  input  logic             faSum,
  input  logic             faCout,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow,
  output logic             resultValid,
  input  logic             resultReady,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             sub_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             run;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startValid) begin
            a_q     <= operandA;
            b_q     <= operandB;
            sub_q   <= opSub;
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            carry_q <= opSub;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q[idx_q] <= faSum;
          carry_q      <= faCout;
          idx_q        <= idx_q + CNT_W'(1);
          if (idx_q == LAST_IDX) begin
            cout_q  <= faCout;
            ovf_q   <= faCin ^ faCout;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (resultReady) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign run         = (state_q == RUN);
  assign faX         = run & a_q[idx_q];
  assign faY         = run & (b_q[idx_q] ^ sub_q);
  assign faCin       = run & carry_q;
  assign startReady  = (state_q == IDLE);
  assign busy        = run;
  assign resultValid = (state_q == DONE);
  assign result      = res_q;
  assign carryOut    = cout_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed vector table, DONE-hold, mid-run reset and back-to-back runs.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rstN;
  logic             startValid;
  logic             startReady;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             opSub;
  logic             faX, faY, faCin, faSum, faCout;
  logic [WIDTH-1:0] result;
  logic             carryOut, overflow, resultValid, resultReady, busy;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rstN(rstN),
    .startValid(startValid), .startReady(startReady),
    .operandA(operandA), .operandB(operandB), .opSub(opSub),
    .faX(faX), .faY(faY), .faCin(faCin), .faSum(faSum), .faCout(faCout),
    .result(result), .carryOut(carryOut), .overflow(overflow),
    .resultValid(resultValid), .resultReady(resultReady), .busy(busy)
  );

  // Stand-in for the shared full-adder cell.
  assign faSum  = faX ^ faY ^ faCin;
  assign faCout = (faX & faY) | (faX & faCin) | (faY & faCin);

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [7:0] r, output logic c, output logic v,
                        output int lat, output int busyc, output int src);
    r = '0; c = 1'b0; v = 1'b0;
    lat = -1; busyc = 0; src = 0;
    @(negedge clk);
    startValid = 1'b1; operandA = a; operandB = b; opSub = s; resultReady = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      startValid = 1'b0;
      operandA = ~a; operandB = ~b; opSub = ~s;
      if (busy) busyc++;
      if (startReady) break;
      src++;
      if (resultValid && lat < 0) begin
        lat = k; r = result; c = carryOut; v = overflow;
        resultReady = 1'b1;
      end
    end
    resultReady = 1'b0;
    chk("valid_after_ack", {31'd0, resultValid}, 32'd0);
  endtask

  task automatic wait_valid(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resultValid) begin k = i; break; end
    end
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [7:0] r, output logic c, output logic v);
    int sa, sb, sr;
    logic [8:0] full;
    sa = $signed(a); sb = $signed(b);
    sr = s ? sa - sb : sa + sb;
    if (s) full = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else   full = {1'b0, a} + {1'b0, b};
    r = full[7:0];
    c = s ? (a >= b) : full[8];
    v = (sr > 127) || (sr < -128);
  endtask

  initial begin
    vec_t       vecs[7];
    logic [7:0] r, er;
    logic       c, v, ec, ev;
    int         lat, busyc, src, k;
    logic [7:0] ra, rb;
    logic       rs;

    vecs[0] = '{8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};

    rstN = 1'b0; startValid = 1'b0; resultReady = 1'b0;
    operandA = '0; operandB = '0; opSub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_startReady", {31'd0, startReady}, 32'd1);
    chk("rst_resultValid", {31'd0, resultValid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fa", {29'd0, faX, faY, faCin}, 32'd0);
    chk("rst_outs", {22'd0, result, carryOut, overflow}, 32'd0);
    rstN = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, c, v, lat, busyc, src);
      chk($sformatf("vec%0d_result", i), {24'd0, r}, {24'd0, vecs[i].res});
      chk($sformatf("vec%0d_carry", i), {31'd0, c}, {31'd0, vecs[i].cout});
      chk($sformatf("vec%0d_ovf", i), {31'd0, v}, {31'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_busy_cycles", i), busyc, 8);
      chk($sformatf("vec%0d_notready_cycles", i), src, 9);
    end

    // DONE hold with resultReady low while new starts are offered.
    @(negedge clk);
    startValid = 1'b1; operandA = 8'h12; operandB = 8'h34; opSub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    startValid = 1'b0;
    wait_valid(k);
    chk("hold_reach_done", k, 8);
    for (int i = 0; i < 5; i++) begin
      startValid = 1'b1; operandA = 8'hC3 + 8'(i); operandB = 8'h0F; opSub = 1'b1;
      @(negedge clk);
      chk($sformatf("hold%0d_result", i), {22'd0, result, carryOut, overflow}, {22'd0, 8'h46, 1'b0, 1'b0});
      chk($sformatf("hold%0d_flags", i), {29'd0, resultValid, startReady, busy}, 32'b100);
      chk($sformatf("hold%0d_fa", i), {29'd0, faX, faY, faCin}, 32'd0);
    end
    resultReady = 1'b1;
    operandA = 8'h01; operandB = 8'h02; opSub = 1'b0;
    @(negedge clk);
    resultReady = 1'b0;
    chk("hold_release_idle", {30'd0, startReady, resultValid}, 32'b10);
    @(negedge clk);
    startValid = 1'b0;
    chk("hold_new_accept", {31'd0, busy}, 32'd1);
    wait_valid(k);
    chk("hold_new_latency", k, 8);
    chk("hold_new_result", {22'd0, result, carryOut, overflow}, {22'd0, 8'h03, 1'b0, 1'b0});
    resultReady = 1'b1;
    @(negedge clk);
    resultReady = 1'b0;

    // Reset mid-run at bit 3.
    startValid = 1'b1; operandA = 8'hAA; operandB = 8'h55; opSub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    startValid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_fa_bit3", {29'd0, faX, faY, faCin}, 32'b100);
    #1 rstN = 1'b0;
    #1;
    chk("abort_flags", {29'd0, startReady, resultValid, busy}, 32'b100);
    chk("abort_fa", {29'd0, faX, faY, faCin}, 32'd0);
    chk("abort_outs", {22'd0, result, carryOut, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, r, c, v, lat, busyc, src);
    chk("post_rst_result", {22'd0, r, c, v}, {22'd0, 8'h02, 1'b0, 1'b0});
    chk("post_rst_latency", lat, 9);

    // Back-to-back with both handshakes held high.
    @(negedge clk);
    startValid = 1'b1; resultReady = 1'b1;
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      operandA = ra; operandB = rb; opSub = rs;
      model(ra, rb, rs, er, ec, ev);
      chk("b2b_ready", {31'd0, startReady}, 32'd1);
      @(posedge clk);
      lat = -1; k = -1; r = '0; c = 1'b0; v = 1'b0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (resultValid && lat < 0) begin lat = i; r = result; c = carryOut; v = overflow; end
        if (startReady) begin k = i; break; end
      end
      chk($sformatf("b2b%0d_result", n), {22'd0, r, c, v}, {22'd0, er, ec, ev});
      chk($sformatf("b2b%0d_interval", n), k, WIDTH + 2);
      if (k < 0) break;
    end
    startValid = 1'b0; resultReady = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
